apir_simd_mac: RTL
==================

APIR_SIMD_MAC -- requirements
Module: apir_simd_mac

Interface
REQ-001 Parameter LANES, default 4, number of independent SIMD lanes.
REQ-002 Parameter LANE_W, default 8, operand width per lane in bits.
REQ-003 Parameter ACC_W, default 20, per-lane result and accumulator width; elaboration SHALL fail if ACC_W < 2*LANE_W+1.
REQ-004 Parameter MAX_BURST, default 16, maximum accumulate beats before a forced emit; range 2..1024.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RSTN  in  1  reset, synchronous, active-low.
REQ-007 IN_VALID  in  1  input beat offered.
REQ-008 IN_READY  out  1  input beat accepted when IN_VALID && IN_READY.
REQ-009 A, B  in  LANES*LANE_W each  lane operands; lane i occupies bits [i*LANE_W +: LANE_W].
REQ-010 C  in  LANES*ACC_W  per-lane addend.
REQ-011 OPMODE  in  2  00 MUL, 01 MULADD, 10 ACC, 11 PASSC; sampled with the beat.
REQ-012 SIGNED  in  1  1 = two's-complement operands and C; 0 = unsigned; sampled with the beat.
REQ-013 IN_LAST  in  1  marks final beat of an ACC burst.
REQ-014 OUT_VALID  out  1  result beat present.
REQ-015 OUT_READY  in  1  downstream accepts when OUT_VALID && OUT_READY.
REQ-016 P  out  LANES*ACC_W  per-lane result, same lane packing as C.
REQ-017 OUT_LAST  out  1  1 when the beat closes an ACC burst via IN_LAST.
REQ-018 OVERFLOW  out  LANES  per-lane saturation flag, qualified by OUT_VALID.

Function
REQ-019 Three pipeline stages SHALL be used: S1 operand register, S2 lane multiply, S3 ALU/accumulate/saturate and output register; latency SHALL be 3 cycles from acceptance to OUT_VALID when unstalled.
REQ-020 The global advance enable SHALL be en = !OUT_VALID || OUT_READY, IN_READY SHALL equal en, and all stages SHALL hold when en=0, with no beat lost, duplicated or reordered.
REQ-021 MUL mode SHALL give P = A*B per lane, extended to ACC_W according to SIGNED.
REQ-022 MULADD mode SHALL give P = C + A*B per lane.
REQ-023 PASSC mode SHALL give P = C with the same 3-cycle latency.
REQ-024 ACC mode SHALL give acc = acc + A*B per beat; non-final beats SHALL produce no OUT_VALID.
REQ-025 An ACC beat with IN_LAST=1 SHALL emit P = final acc with OUT_LAST=1 and SHALL clear acc and the beat counter.
REQ-026 A beat counter SHALL count ACC beats; when it reaches MAX_BURST without IN_LAST, the block SHALL emit P=acc with OUT_LAST=0, clear acc, and continue the burst from count 0.
REQ-027 A non-ACC beat arriving while a partial acc is held SHALL discard the partial acc (no output for it), clear the counter and be processed normally.
REQ-028 Each add SHALL saturate: for SIGNED, clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; for unsigned, clamp to 2^ACC_W-1.
REQ-029 In ACC mode, saturation SHALL clamp the running acc, and the lane OVERFLOW SHALL be the OR over the burst's beats, reported on the emitting beat.
REQ-030 OUT_LAST SHALL be 0 for MUL, MULADD and PASSC beats.

Reset
REQ-031 While RSTN=0 at a clock edge, all stage valids, acc, the beat counter, P, OUT_LAST and OVERFLOW SHALL become 0 and OUT_VALID SHALL become 0.
REQ-032 IN_READY SHALL be 1 in the first cycle after reset release.
REQ-033 Reset asserted mid-burst or mid-stall SHALL discard all in-flight beats without emitting them.

Structure
REQ-034 Package apir_simd_pkg SHALL hold the OPMODE encodings and the signed/unsigned saturate function.
REQ-035 Sub-module apir_simd_lane SHALL implement one lane (multiply, add, saturate, accumulator) and SHALL be instantiated LANES times by generate; the valid, handshake and counter logic SHALL stay in apir_simd_mac.

Verification (defaults LANES=4, LANE_W=8, ACC_W=20, MAX_BURST=16)
REQ-036 Reset: hold RSTN=0 for 2 cycles -> OUT_VALID=0, P=0, OVERFLOW=0, then IN_READY=1 after release.
REQ-037 Signed MUL: A lanes {3,-2,127,-128}, B lanes {5,7,127,-128} -> exactly 3 cycles later P={15,-14,16129,16384}, OVERFLOW=0000.
REQ-038 ACC burst: 4 beats with A=B=10 in every lane and IN_LAST on beat 4 -> exactly one output beat, P=400 in each lane, OUT_LAST=1.
REQ-039 Saturation: MULADD, SIGNED=1, C=524272 and A=B=127 in every lane -> P=524287 and OVERFLOW=1111.
REQ-040 Backpressure: hold OUT_READY=0 while offering 5 MUL beats -> IN_READY falls when OUT_VALID rises, and after OUT_READY=1 all accepted beats appear in order with none lost.
REQ-041 Forced emit: 20 ACC beats with A=B=1 and IN_LAST on beat 20 -> first output P=16 with OUT_LAST=0, second output P=4 with OUT_LAST=1.

Source files
------------

// File: rtl/apir_simd_pkg.sv
// Shared opcode encodings and the saturation decision used by every SIMD MAC lane.
package apir_simd_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULADD = 2'b01,
        OP_ACC    = 2'b10,
        OP_PASSC  = 2'b11
    } opmode_e;

    // Looks at the top two bits of a one-bit-wider sum and returns {overflow, clamp_to_min}.
    // Unsigned sums can only overflow upward (carry out), so clamp_to_min is 0 there.
    function automatic logic [1:0] sat_decode(input logic sgn, input logic ext_msb, input logic msb);
        logic ov;
        logic neg;
        ov  = sgn ? (ext_msb ^ msb) : ext_msb;
        neg = sgn & ext_msb;
        return {ov, neg};
    endfunction

endpackage

// File: rtl/apir_simd_lane.sv
// One SIMD lane: operand register, multiply register, then add/accumulate with saturation.
module apir_simd_lane
    import apir_simd_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic              i_s1_sgn,
    input  logic              i_fire,
    input  logic              i_emit,
    input  opmode_e           i_s2_op,
    input  logic              i_s2_sgn,
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic [ACC_W-1:0]  i_c,
    output logic [ACC_W-1:0]  o_p,
    output logic              o_ov
);
    localparam int PW = 2*LANE_W + 2;

    logic [LANE_W-1:0] r_a, r_b;
    logic [ACC_W-1:0]  r_c1, r_c2, r_prod, r_acc, r_p;
    logic              r_ovacc, r_ov;

    logic [PW-1:0]     w_ax, w_bx, w_prod;
    logic [ACC_W-1:0]  w_pext, w_base, w_sat, w_res;
    logic [ACC_W:0]    w_sum;
    logic [1:0]        w_sd;
    logic              w_ov;

    // Extending both operands to the full product width keeps the multiply exact for either signedness.
    assign w_ax   = {{(PW-LANE_W){i_s1_sgn & r_a[LANE_W-1]}}, r_a};
    assign w_bx   = {{(PW-LANE_W){i_s1_sgn & r_b[LANE_W-1]}}, r_b};
    assign w_prod = w_ax * w_bx;

    if (ACC_W > PW) begin : g_pext_wide
        assign w_pext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    end else begin : g_pext_narrow
        assign w_pext = w_prod[ACC_W-1:0];
    end

    assign w_base = (i_s2_op == OP_ACC) ? r_acc : r_c2;
    assign w_sum  = {i_s2_sgn & w_base[ACC_W-1], w_base} + {i_s2_sgn & r_prod[ACC_W-1], r_prod};
    assign w_sd   = sat_decode(i_s2_sgn, w_sum[ACC_W], w_sum[ACC_W-1]);

    always_comb begin
        w_sat = w_sum[ACC_W-1:0];
        if (w_sd[1]) begin
            if (!i_s2_sgn)    w_sat = '1;
            else if (w_sd[0]) w_sat = {1'b1, {(ACC_W-1){1'b0}}};
            else              w_sat = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_comb begin
        w_res = w_sat;
        w_ov  = w_sd[1];
        case (i_s2_op)
            OP_MUL:   begin w_res = r_prod; w_ov = 1'b0; end
            OP_PASSC: begin w_res = r_c2;   w_ov = 1'b0; end
            OP_ACC:   w_ov = r_ovacc | w_sd[1];
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_ovacc <= 1'b0;
            r_p     <= '0;
            r_ov    <= 1'b0;
        end else begin
            if (i_en) begin
                r_a    <= i_a;
                r_b    <= i_b;
                r_c1   <= i_c;
                r_c2   <= r_c1;
                r_prod <= w_pext;
            end
            if (i_fire) begin
                // Any emit or non-ACC beat leaves the accumulator empty for the next burst.
                if (i_s2_op == OP_ACC && !i_emit) begin
                    r_acc   <= w_res;
                    r_ovacc <= w_ov;
                end else begin
                    r_acc   <= '0;
                    r_ovacc <= 1'b0;
                end
                if (i_emit) begin
                    r_p  <= w_res;
                    r_ov <= w_ov;
                end
            end
        end
    end

    assign o_p  = r_p;
    assign o_ov = r_ov;

endmodule

// File: rtl/apir_simd_mac.sv
// Three-stage SIMD multiply/accumulate with a single global stall and burst-emit control.
module apir_simd_mac
    import apir_simd_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int LANE_W    = 8,
    parameter int ACC_W     = 20,
    parameter int MAX_BURST = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [LANES*LANE_W-1:0] i_a,
    input  logic [LANES*LANE_W-1:0] i_b,
    input  logic [LANES*ACC_W-1:0]  i_c,
    input  logic [1:0]             i_opmode,
    input  logic                   i_signed,
    input  logic                   i_in_last,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [LANES*ACC_W-1:0]  o_p,
    output logic                   o_out_last,
    output logic [LANES-1:0]       o_overflow
);
    localparam int CNT_W = $clog2(MAX_BURST);

    if (ACC_W < 2*LANE_W + 1) begin : g_bad_acc_w
        $error("apir_simd_mac: ACC_W must be at least 2*LANE_W+1");
    end
    if (MAX_BURST < 2 || MAX_BURST > 1024) begin : g_bad_burst
        $error("apir_simd_mac: MAX_BURST must be within 2..1024");
    end

    logic             r_s1_vld, r_s1_sgn, r_s1_last;
    logic             r_s2_vld, r_s2_sgn, r_s2_last;
    opmode_e          r_s1_op, r_s2_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_vld, r_out_last;

    logic w_en, w_fire, w_emit, w_s2_acc;

    assign w_en     = !r_out_vld || i_out_ready;
    assign w_fire   = w_en && r_s2_vld;
    assign w_s2_acc = (r_s2_op == OP_ACC);
    // An ACC beat emits on IN_LAST or when it would be the MAX_BURST-th beat of the run.
    assign w_emit   = !w_s2_acc || r_s2_last || (r_cnt == CNT_W'(MAX_BURST-1));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_s1_vld   <= 1'b0;
            r_s1_sgn   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_op    <= OP_MUL;
            r_s2_vld   <= 1'b0;
            r_s2_sgn   <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_op    <= OP_MUL;
            r_cnt      <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            if (w_en) begin
                r_s1_vld  <= i_in_valid;
                r_s1_sgn  <= i_signed;
                r_s1_last <= i_in_last;
                r_s1_op   <= opmode_e'(i_opmode);
                r_s2_vld  <= r_s1_vld;
                r_s2_sgn  <= r_s1_sgn;
                r_s2_last <= r_s1_last;
                r_s2_op   <= r_s1_op;
                r_out_vld <= r_s2_vld && w_emit;
            end
            if (w_fire) begin
                r_cnt <= (w_s2_acc && !w_emit) ? r_cnt + 1'b1 : '0;
                if (w_emit) r_out_last <= w_s2_acc && r_s2_last;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        apir_simd_lane #(
            .LANE_W (LANE_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rstn   (i_rstn),
            .i_en     (w_en),
            .i_s1_sgn (r_s1_sgn),
            .i_fire   (w_fire),
            .i_emit   (w_emit),
            .i_s2_op  (r_s2_op),
            .i_s2_sgn (r_s2_sgn),
            .i_a      (i_a[g*LANE_W +: LANE_W]),
            .i_b      (i_b[g*LANE_W +: LANE_W]),
            .i_c      (i_c[g*ACC_W +: ACC_W]),
            .o_p      (o_p[g*ACC_W +: ACC_W]),
            .o_ov     (o_overflow[g])
        );
    end

    assign o_in_ready  = w_en;
    assign o_out_valid = r_out_vld;
    assign o_out_last  = r_out_last;

endmodule
